// File: rtl/bus_dbg_master_if.sv
// Debug bus master interface bundle.
// Groups the UART byte stream (rx in, tx out with valid/ready), the
// single-beat peripheral register bus (we/addr/data) and the busy flag.
//   master modport : the bus_dbg_master view (drives tx, bus and busy)
//   slave  modport : the surrounding system view (UART rx/tx ends and the
//                    peripheral slave that returns data_i)
interface bus_dbg_master_if;
   logic [7:0]  rx_data_i;
   logic        rx_valid_i;
   logic [7:0]  tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i;
   logic        we_o;
   logic [31:0] addr_o;
   logic [31:0] data_o;
   logic [31:0] data_i;
   logic        busy_o;

   modport master (
      input  rx_data_i, rx_valid_i, tx_ready_i, data_i,
      output tx_data_o, tx_valid_o, we_o, addr_o, data_o, busy_o
   );

   modport slave (
      output rx_data_i, rx_valid_i, tx_ready_i, data_i,
      input  tx_data_o, tx_valid_o, we_o, addr_o, data_o, busy_o
   );
endinterface

// File: rtl/bus_dbg_master.sv
// Debug bus initiator.
// Decodes 'W' (0x57) + addr[4] + data[4] and 'R' (0x52) + addr[4] frames
// arriving from the UART receiver and issues one single-beat transaction
// on the peripheral register bus. Writes reply 'K' (0x4B), reads reply the
// four bytes of read data MSB first, unknown command bytes reply '?' (0x3F).
// A frame stalled mid-way for TIMEOUT cycles is silently dropped.
// Ports:
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   bus   : bus_dbg_master_if.master (rx stream, tx stream with ready,
//           we/addr/data bus, read data in, busy flag)
// Parameters:
//   READ_LAT : cycles from addr_o stable to data_i sampled (0..7)
//   TIMEOUT  : idle cycles inside a frame before it is dropped
//   TO_W     : width of the inter-byte timeout counter
module bus_dbg_master #(
   parameter int READ_LAT = 1,
   parameter int TIMEOUT  = 500000,
   parameter int TO_W     = 20
) (
   input logic clk,
   input logic rst_n,
   bus_dbg_master_if.master bus
);

   localparam logic [7:0]      CMD_WR  = 8'h57;
   localparam logic [7:0]      CMD_RD  = 8'h52;
   localparam logic [7:0]      RPL_OK  = 8'h4B;
   localparam logic [7:0]      RPL_ERR = 8'h3F;
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
   localparam logic [2:0]      LAT     = 3'(READ_LAT);

   typedef enum logic [2:0] {IDLE, ADDR, DATA, WR, RD_WAIT, TX} state_t;

   state_t            state;
   state_t            state_next;
   logic              is_write;
   logic [1:0]        byte_cnt;
   logic [31:0]       addr_sr;
   logic [23:0]       data_sr;
   logic [31:0]       addr_q;
   logic [31:0]       data_q;
   logic [31:0]       reply_q;
   logic [2:0]        tx_left;
   logic [2:0]        lat_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              in_frame;
   logic              timeout_hit;
   logic              last_byte;
   logic              tx_take;

   // A frame times out only while collecting address/data bytes; an arriving
   // byte on the expiry cycle keeps the frame alive.
   assign in_frame    = (state == ADDR) || (state == DATA);
   assign timeout_hit = in_frame && !bus.rx_valid_i && (to_cnt == TO_LAST);
   assign last_byte   = bus.rx_valid_i && (byte_cnt == 2'd3);
   assign tx_take     = (state == TX) && bus.tx_ready_i;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode. Bytes arriving in WR, RD_WAIT or TX are ignored.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (bus.rx_valid_i) begin
               if (bus.rx_data_i == CMD_WR || bus.rx_data_i == CMD_RD) begin
                  state_next = ADDR;
               end else begin
                  state_next = TX;
               end
            end
         end
         ADDR: begin
            if (last_byte) begin
               state_next = is_write ? DATA : RD_WAIT;
            end else if (timeout_hit) begin
               state_next = IDLE;
            end
         end
         DATA: begin
            if (last_byte) begin
               state_next = WR;
            end else if (timeout_hit) begin
               state_next = IDLE;
            end
         end
         WR: begin
            state_next = TX;
         end
         RD_WAIT: begin
            if (lat_cnt == LAT) begin
               state_next = TX;
            end
         end
         TX: begin
            if (tx_take && tx_left == 3'd1) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Datapath: byte assembly, bus address/data registers, read capture and
   // the reply shift register. The reply byte on the wire is always the top
   // byte of reply_q, so it stays stable until the transmitter takes it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         is_write <= 1'b0;
         byte_cnt <= 2'd0;
         addr_sr  <= 32'd0;
         data_sr  <= 24'd0;
         addr_q   <= 32'd0;
         data_q   <= 32'd0;
         reply_q  <= 32'd0;
         tx_left  <= 3'd0;
         lat_cnt  <= 3'd0;
         to_cnt   <= '0;
      end else begin
         if (in_frame && !bus.rx_valid_i && !timeout_hit) begin
            to_cnt <= to_cnt + 1'b1;
         end else begin
            to_cnt <= '0;
         end

         case (state)
            IDLE: begin
               if (bus.rx_valid_i) begin
                  is_write <= (bus.rx_data_i == CMD_WR);
                  byte_cnt <= 2'd0;
                  if (bus.rx_data_i != CMD_WR && bus.rx_data_i != CMD_RD) begin
                     reply_q <= {RPL_ERR, 24'd0};
                     tx_left <= 3'd1;
                  end
               end
            end
            ADDR: begin
               if (bus.rx_valid_i) begin
                  addr_sr  <= {addr_sr[23:0], bus.rx_data_i};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (last_byte && !is_write) begin
                     addr_q  <= {addr_sr[23:0], bus.rx_data_i};
                     lat_cnt <= 3'd0;
                  end
               end
            end
            DATA: begin
               if (bus.rx_valid_i) begin
                  data_sr  <= {data_sr[15:0], bus.rx_data_i};
                  byte_cnt <= byte_cnt + 2'd1;
                  if (last_byte) begin
                     addr_q <= addr_sr;
                     data_q <= {data_sr, bus.rx_data_i};
                  end
               end
            end
            WR: begin
               reply_q <= {RPL_OK, 24'd0};
               tx_left <= 3'd1;
            end
            RD_WAIT: begin
               if (lat_cnt == LAT) begin
                  reply_q <= bus.data_i;
                  tx_left <= 3'd4;
               end else begin
                  lat_cnt <= lat_cnt + 3'd1;
               end
            end
            TX: begin
               if (bus.tx_ready_i) begin
                  reply_q <= {reply_q[23:0], 8'h00};
                  tx_left <= tx_left - 3'd1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign bus.we_o       = (state == WR);
   assign bus.tx_valid_o = (state == TX);
   assign bus.busy_o     = (state != IDLE);
   assign bus.tx_data_o  = reply_q[31:24];
   assign bus.addr_o     = addr_q;
   assign bus.data_o     = data_q;

endmodule

// File: tb/tb_bus_dbg_master.sv
// Testbench for bus_dbg_master.
// A frame-level reference model (a 16-entry register file plus queues of
// expected bus writes and expected reply bytes) is updated whenever a frame
// is issued; a negedge monitor pops and compares whenever the DUT pulses
// we_o or hands a byte to the transmitter. A behavioural slave with one
// cycle of read latency answers on data_i.
module tb_bus_dbg_master;

   localparam int READ_LAT = 1;
   localparam int TIMEOUT  = 100;
   localparam int TO_W     = 20;

   logic clk;
   logic rst_n;

   bus_dbg_master_if bus_if ();

   bus_dbg_master #(
      .READ_LAT(READ_LAT),
      .TIMEOUT (TIMEOUT),
      .TO_W    (TO_W)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if.master)
   );

   int          vectors;
   int          miscompares;
   logic [63:0] exp_wr[$];
   logic [7:0]  exp_tx[$];
   logic [31:0] model_mem[16];
   logic [31:0] slave_mem[16];
   int          ready_mode;
   logic        prev_stall;
   logic [7:0]  prev_data;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Peripheral slave: registered read data, so one cycle of latency.
   always @(posedge clk) begin
      if (bus_if.we_o) begin
         slave_mem[bus_if.addr_o[3:0]] <= bus_if.data_o;
      end
      bus_if.data_i <= slave_mem[bus_if.addr_o[3:0]];
   end

   // Transmitter ready: 0 = stalled, 1 = always ready, 2 = random.
   initial begin
      bus_if.tx_ready_i = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (ready_mode == 2) begin
            bus_if.tx_ready_i = 1'($urandom_range(0, 1));
         end else begin
            bus_if.tx_ready_i = (ready_mode == 1);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: scoreboard pops on every bus write and every accepted byte.
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall <= 1'b0;
      end else begin
         if (prev_stall) begin
            checkOutput("stall_valid", 32'(bus_if.tx_valid_o), 32'd1);
            checkOutput("stall_data", 32'(bus_if.tx_data_o), 32'(prev_data));
         end
         if (bus_if.we_o) begin
            if (exp_wr.size() == 0) begin
               checkOutput("spurious_we", 32'(bus_if.we_o), 32'd0);
            end else begin
               logic [63:0] e;
               e = exp_wr.pop_front();
               checkOutput("wr_addr", bus_if.addr_o, e[63:32]);
               checkOutput("wr_data", bus_if.data_o, e[31:0]);
            end
         end
         if (bus_if.tx_valid_o && bus_if.tx_ready_i) begin
            if (exp_tx.size() == 0) begin
               checkOutput("spurious_tx", 32'(bus_if.tx_valid_o), 32'd0);
            end else begin
               logic [7:0] b;
               b = exp_tx.pop_front();
               checkOutput("tx_byte", 32'(bus_if.tx_data_o), 32'(b));
            end
         end
         prev_stall <= bus_if.tx_valid_o && !bus_if.tx_ready_i;
         prev_data  <= bus_if.tx_data_o;
      end
   end

   // Caller is always 1 time unit after a rising edge.
   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      bus_if.rx_data_i  = b;
      bus_if.rx_valid_i = 1'b1;
      @(posedge clk);
      #1;
      bus_if.rx_valid_i = 1'b0;
   endtask

   task automatic waitIdle(input int bound);
      int n;
      n = 0;
      while (bus_if.busy_o && n < bound) begin
         idleCycles(1);
         n++;
      end
      checkOutput("idle_reached", 32'(bus_if.busy_o), 32'd0);
      checkOutput("wr_queue_drained", 32'(exp_wr.size()), 32'd0);
      checkOutput("tx_queue_drained", 32'(exp_tx.size()), 32'd0);
   endtask

   // long_pos selects a byte preceded by TIMEOUT-1 idle cycles (0 = none).
   task automatic issueWrite(input logic [31:0] a, input logic [31:0] d,
                             input int maxgap, input int long_pos);
      logic [7:0] fr[9];
      fr[0] = 8'h57;
      for (int i = 0; i < 4; i++) begin
         fr[1 + i] = 8'(a >> (24 - 8 * i));
         fr[5 + i] = 8'(d >> (24 - 8 * i));
      end
      model_mem[a[3:0]] = d;
      exp_wr.push_back({a, d});
      exp_tx.push_back(8'h4B);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) begin
            idleCycles((i == long_pos) ? TIMEOUT - 1 : int'($urandom_range(0, maxgap)));
         end
         applyStimulus(fr[i]);
      end
   endtask

   task automatic issueRead(input logic [31:0] a, input int maxgap);
      logic [31:0] v;
      v = model_mem[a[3:0]];
      for (int i = 0; i < 4; i++) begin
         exp_tx.push_back(8'(v >> (24 - 8 * i)));
      end
      applyStimulus(8'h52);
      for (int i = 0; i < 4; i++) begin
         idleCycles(int'($urandom_range(0, maxgap)));
         applyStimulus(8'(a >> (24 - 8 * i)));
      end
   endtask

   task automatic issueUnknown(input logic [7:0] b);
      exp_tx.push_back(8'h3F);
      applyStimulus(b);
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic [7:0]  b;
      int          kind;

      vectors            = 0;
      miscompares        = 0;
      ready_mode         = 1;
      prev_stall         = 1'b0;
      prev_data          = 8'h00;
      bus_if.rx_data_i   = 8'h00;
      bus_if.rx_valid_i  = 1'b0;
      rst_n              = 1'b0;

      // Reset state.
      #2;
      checkOutput("rst_we", 32'(bus_if.we_o), 32'd0);
      checkOutput("rst_tx_valid", 32'(bus_if.tx_valid_o), 32'd0);
      checkOutput("rst_tx_data", 32'(bus_if.tx_data_o), 32'd0);
      checkOutput("rst_busy", 32'(bus_if.busy_o), 32'd0);
      checkOutput("rst_addr", bus_if.addr_o, 32'd0);
      checkOutput("rst_data", bus_if.data_o, 32'd0);
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Write addr 0 = 5 with exact pulse and reply timing.
      issueWrite(32'h0, 32'h5, 0, 0);
      checkOutput("t1_we_pulse", 32'(bus_if.we_o), 32'd1);
      checkOutput("t1_addr", bus_if.addr_o, 32'h0);
      checkOutput("t1_data", bus_if.data_o, 32'h5);
      checkOutput("t1_tx_early", 32'(bus_if.tx_valid_o), 32'd0);
      idleCycles(1);
      checkOutput("t1_we_single", 32'(bus_if.we_o), 32'd0);
      checkOutput("t1_tx_valid", 32'(bus_if.tx_valid_o), 32'd1);
      waitIdle(50);
      checkOutput("t1_slave_reg", slave_mem[0], 32'h5);

      // Give every slave register a known value.
      for (int i = 1; i < 16; i++) begin
         issueWrite({$urandom_range(0, 255), 24'd0} | 32'(i), $urandom, 1, 0);
         waitIdle(50);
      end

      // Read with transmitter backpressure.
      issueWrite(32'h1, 32'h3, 0, 0);
      waitIdle(50);
      ready_mode = 0;
      issueRead(32'h1, 0);
      begin
         int n;
         n = 0;
         while (!bus_if.tx_valid_o && n < 20) begin
            idleCycles(1);
            n++;
         end
      end
      checkOutput("t2_tx_valid", 32'(bus_if.tx_valid_o), 32'd1);
      checkOutput("t2_addr", bus_if.addr_o, 32'h1);
      idleCycles(10);
      ready_mode = 1;
      waitIdle(50);

      // Unknown command byte.
      a = bus_if.addr_o;
      issueUnknown(8'h41);
      waitIdle(20);
      checkOutput("t3_addr_held", bus_if.addr_o, a);

      // Timeout exactly at the boundary, then a normal write.
      applyStimulus(8'h57);
      applyStimulus(8'h00);
      applyStimulus(8'h00);
      idleCycles(TIMEOUT - 1);
      checkOutput("t4_busy_before_expiry", 32'(bus_if.busy_o), 32'd1);
      idleCycles(1);
      checkOutput("t4_busy_after_expiry", 32'(bus_if.busy_o), 32'd0);
      idleCycles(5);
      issueWrite(32'h0000_0002, 32'hCAFE_0002, 0, 0);
      waitIdle(50);

      // A byte landing on the expiry cycle keeps the frame alive.
      issueWrite(32'h0000_0007, 32'h1234_5677, 0, 4);
      waitIdle(50);

      // Command byte during a stalled reply is discarded.
      ready_mode = 0;
      issueRead(32'h0000_0007, 0);
      idleCycles(3);
      applyStimulus(8'h57);
      idleCycles(3);
      ready_mode = 1;
      waitIdle(50);
      idleCycles(5);
      checkOutput("t5_no_new_frame", 32'(bus_if.busy_o), 32'd0);

      // Randomised mix of frames with random gaps and random ready.
      ready_mode = 2;
      for (int f = 0; f < 40; f++) begin
         kind = int'($urandom_range(0, 19));
         a    = $urandom;
         d    = $urandom;
         if (kind < 9) begin
            issueWrite(a, d, 3, 0);
            waitIdle(200);
         end else if (kind < 16) begin
            issueRead(a, 3);
            waitIdle(200);
            checkOutput("rand_rd_addr", bus_if.addr_o, a);
         end else begin
            do begin
               b = 8'($urandom);
            end while (b == 8'h57 || b == 8'h52);
            issueUnknown(b);
            waitIdle(200);
         end
         idleCycles(int'($urandom_range(0, 3)));
      end
      ready_mode = 1;
      issueWrite(32'hA5A5_0003, 32'h5A5A_1234, 0, 0);
      waitIdle(50);

      // Reset mid-frame.
      applyStimulus(8'h57);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(8'h00);
      end
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("t6_we", 32'(bus_if.we_o), 32'd0);
      checkOutput("t6_tx_valid", 32'(bus_if.tx_valid_o), 32'd0);
      checkOutput("t6_tx_data", 32'(bus_if.tx_data_o), 32'd0);
      checkOutput("t6_busy", 32'(bus_if.busy_o), 32'd0);
      checkOutput("t6_addr", bus_if.addr_o, 32'd0);
      checkOutput("t6_data", bus_if.data_o, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #3;
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      idleCycles(20);
      checkOutput("t6_idle_after", 32'(bus_if.busy_o), 32'd0);
      issueWrite(32'h0000_000F, 32'hDEAD_BEEF, 0, 0);
      waitIdle(50);
      issueRead(32'h0000_000F, 0);
      waitIdle(50);

      idleCycles(5);
      checkOutput("end_wr_queue", 32'(exp_wr.size()), 32'd0);
      checkOutput("end_tx_queue", 32'(exp_tx.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute time limit so the bench can never hang.
   initial begin
      #2000000;
      $display("[TB] FAIL global_timeout: simulation did not finish");
      $fatal(1, "[TB] time limit reached");
   end

endmodule
